mux_pipe: RTL and testbench
===========================

MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 Parameter NUM_CH, default 16, number of input channels (2..64).
REQ-002 Parameter DATA_W, default 1, bits per channel (1..32).
REQ-003 Parameter SEL_W, default clog2(NUM_CH), select width; derived, not overridden.
REQ-004 The port list SHALL be exactly as follows:
- clk_pad  in  1  sole clock, rising edge.
- rst_n_pad  in  1  asynchronous active-low reset.
- data_pad  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- sel_pad  in  SEL_W  select value to load.
- sel_ld_pad  in  1  load sel_pad into select register.
- scan_pad  in  1  1 = auto-advance select after each accepted transfer.
- en_pad  in  1  output gate; 0 forces captured data to zero.
- in_valid_pad  in  1  upstream sample request.
- in_ready_pad  out  1  block can accept a sample.
- out_pad  out  DATA_W  selected data.
- out_valid_pad  out  1  out_pad holds a valid sample.
- out_ready_pad  in  1  downstream consumes the sample.
- sel_err_pad  out  1  sticky flag, select register holds a value >= NUM_CH.

Function
REQ-005 An accept SHALL occur when in_valid_pad and in_ready_pad are both 1 at a rising edge.
REQ-006 On accept, the captured word SHALL be en_pad ? channel[sel_q] : 0; if sel_q >= NUM_CH, it SHALL be 0.
REQ-007 Captured words SHALL enter a 2-entry FIFO (skid buffer) and appear on out_pad in acceptance order.
REQ-008 Latency from accept to out_valid_pad=1 SHALL be 1 cycle when the FIFO is empty.
REQ-009 A pop SHALL occur when out_valid_pad and out_ready_pad are both 1; out_pad SHALL hold stable while out_valid_pad=1 and out_ready_pad=0.
REQ-010 in_ready_pad SHALL be registered, equal to (FIFO count < 2), and SHALL NOT combinationally depend on out_ready_pad.
REQ-011 Push and pop in the same cycle SHALL leave the count unchanged and lose no data, including at count 1 and count 2.
REQ-012 Push with the FIFO full SHALL be impossible by REQ-010; pop with the FIFO empty SHALL be ignored.
REQ-013 While out_valid_pad=0, out_pad SHALL be 0.
REQ-014 Select register sel_q: sel_ld_pad=1 SHALL load sel_pad at the edge.
REQ-015 If scan_pad=1, sel_ld_pad=0 and an accept occurs, sel_q SHALL increment, wrapping NUM_CH-1 -> 0.
REQ-016 sel_ld_pad SHALL take priority over scan increment in the same cycle.
REQ-017 An accept coincident with a select load or increment SHALL use the old sel_q; the new value SHALL apply from the next cycle.
REQ-018 sel_err_pad SHALL set when sel_q >= NUM_CH after a load, and SHALL stay set until reset; it is never set when NUM_CH is a power of two.
REQ-019 Data path SHALL be 2 states per FIFO slot (valid/empty), with no other FSM; control state = {count[1:0], rd_ptr, wr_ptr, sel_q, sel_err}.

Reset
REQ-020 Asserting rst_n_pad low SHALL immediately clear the FIFO count, pointers, sel_q, sel_err_pad, out_valid_pad and out_pad to 0, and set in_ready_pad to 0.
REQ-021 in_ready_pad SHALL rise on the first rising edge after rst_n_pad deasserts.
REQ-022 Reset mid-transfer SHALL discard all buffered words; nothing SHALL be emitted after release until a new accept.

Structure
REQ-023 Package mux_pipe_pkg SHALL hold the default NUM_CH/DATA_W constants, a clog2 function and the FIFO depth constant (2).
REQ-024 One sub-module, mux_pipe_skid (2-entry valid/ready buffer, DATA_W parameter), SHALL implement REQ-007 to REQ-012; the select and mux logic SHALL reside in mux_pipe.

Verification
REQ-025 The bench SHALL cover these directed scenarios with NUM_CH=16, DATA_W=1:
- data_pad=16'hA5C3, load sel=5, en=1, one accept, out_ready=1 -> out_pad=0 with out_valid one cycle later; repeat with sel=0 -> out_pad=1.
- scan=1, sel loaded 14, 4 back-to-back accepts with data_pad=16'hFFFF -> channels 14, 15, 0, 1 used; sel_q=2 at end.
- out_ready=0 with 3 valid cycles -> 2 accepts, then in_ready=0; out_pad is stable; out_ready=1 -> words drain in order, in_ready returns to 1.
- en=0, accept with data all-ones -> out_pad=0, out_valid=1.
- NUM_CH=12 instance, load sel=13 -> sel_err_pad=1 next cycle; accept yields 0; sel_err_pad holds after reloading sel=3.
- Reset asserted with 2 words buffered -> out_valid=0 immediately; after release, no output without a new accept.

Source files
------------

// File: rtl/mux_pipe_pkg.sv
// Shared constants and helpers for the mux_pipe channel selector and its
// output skid buffer.
package mux_pipe_pkg;

  localparam int unsigned NUM_CH_DEF = 16;
  localparam int unsigned DATA_W_DEF = 1;
  localparam int unsigned FIFO_DEPTH = 2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_pipe_if.sv
// Valid/ready stream bundle linking the select/mux stage to the skid buffer.
interface mux_pipe_if
  import mux_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/mux_pipe_skid.sv
// Two-entry valid/ready buffer. The upstream ready is registered from the
// next occupancy, so it never depends combinationally on downstream ready.
module mux_pipe_skid
  import mux_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_pipe_if.slave  up,
  mux_pipe_if.master dn
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [1:0]        count;
  logic [1:0]        count_n;
  logic              rd_ptr;
  logic              wr_ptr;
  logic              ready_q;
  logic              push;
  logic              pop;

  always_comb begin
    push    = up.valid & ready_q;
    pop     = (count != 2'd0) & dn.ready;
    count_n = count + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      ready_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      count   <= count_n;
      ready_q <= (32'(count_n) < FIFO_DEPTH);
      if (push) begin
        mem[wr_ptr] <= up.data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  assign up.ready = ready_q;
  assign dn.valid = (count != 2'd0);
  assign dn.data  = dn.valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/mux_pipe.sv
// Channel multiplexer with a loadable/auto-scanning select register feeding
// a two-entry skid buffer toward the output.
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter  int unsigned NUM_CH = NUM_CH_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned SEL_W  = clog2(NUM_CH)
) (
  input  logic                     clk_pad,
  input  logic                     rst_n_pad,
  input  logic [NUM_CH*DATA_W-1:0] data_pad,
  input  logic [SEL_W-1:0]         sel_pad,
  input  logic                     sel_ld_pad,
  input  logic                     scan_pad,
  input  logic                     en_pad,
  input  logic                     in_valid_pad,
  output logic                     in_ready_pad,
  output logic [DATA_W-1:0]        out_pad,
  output logic                     out_valid_pad,
  input  logic                     out_ready_pad,
  output logic                     sel_err_pad
);

  mux_pipe_if #(.DATA_W(DATA_W)) cap_s ();
  mux_pipe_if #(.DATA_W(DATA_W)) out_s ();

  logic [SEL_W-1:0]  sel_q;
  logic              sel_err_q;
  logic              accept;
  logic [DATA_W-1:0] cap_word;

  // Out-of-range selects match no channel and therefore capture zero.
  always_comb begin
    cap_word = '0;
    if (en_pad) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (sel_q == SEL_W'(k)) cap_word = data_pad[k*DATA_W +: DATA_W];
      end
    end
  end

  assign accept        = in_valid_pad & cap_s.ready;
  assign cap_s.valid   = in_valid_pad;
  assign cap_s.data    = cap_word;
  assign in_ready_pad  = cap_s.ready;
  assign out_pad       = out_s.data;
  assign out_valid_pad = out_s.valid;
  assign out_s.ready   = out_ready_pad;
  assign sel_err_pad   = sel_err_q;

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      sel_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      if (sel_ld_pad) begin
        sel_q <= sel_pad;
        if (32'(sel_pad) >= NUM_CH) sel_err_q <= 1'b1;
      end else if (scan_pad && accept) begin
        sel_q <= (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
      end
    end
  end

  mux_pipe_skid #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk_pad),
    .rst_n (rst_n_pad),
    .up    (cap_s.slave),
    .dn    (out_s.master)
  );

endmodule

// File: tb/tb_mux_pipe.sv
// Directed bench for mux_pipe: a 16-channel instance for the datapath and a
// 12-channel instance for out-of-range select handling.
module tb_mux_pipe;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-channel, 1-bit instance
  mux_pipe_if #(.DATA_W(16)) a_in ();
  mux_pipe_if #(.DATA_W(1))  a_out ();
  logic [3:0] a_sel;
  logic       a_sel_ld, a_scan, a_en, a_sel_err;

  mux_pipe #(.NUM_CH(16), .DATA_W(1)) dut_a (
    .clk_pad       (clk),
    .rst_n_pad     (rst_n),
    .data_pad      (a_in.data),
    .sel_pad       (a_sel),
    .sel_ld_pad    (a_sel_ld),
    .scan_pad      (a_scan),
    .en_pad        (a_en),
    .in_valid_pad  (a_in.valid),
    .in_ready_pad  (a_in.ready),
    .out_pad       (a_out.data),
    .out_valid_pad (a_out.valid),
    .out_ready_pad (a_out.ready),
    .sel_err_pad   (a_sel_err)
  );

  // 12-channel, 1-bit instance
  logic [11:0] b_data;
  logic [3:0]  b_sel;
  logic        b_sel_ld, b_in_valid, b_in_ready, b_out, b_out_valid, b_sel_err;

  mux_pipe #(.NUM_CH(12), .DATA_W(1)) dut_b (
    .clk_pad       (clk),
    .rst_n_pad     (rst_n),
    .data_pad      (b_data),
    .sel_pad       (b_sel),
    .sel_ld_pad    (b_sel_ld),
    .scan_pad      (1'b0),
    .en_pad        (1'b1),
    .in_valid_pad  (b_in_valid),
    .in_ready_pad  (b_in_ready),
    .out_pad       (b_out),
    .out_valid_pad (b_out_valid),
    .out_ready_pad (1'b1),
    .sel_err_pad   (b_sel_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [3:0] s);
    a_sel    = s;
    a_sel_ld = 1'b1;
    step();
    a_sel_ld = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (a_in.ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", a_in.ready); end
    total++; if (a_out.valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", a_out.valid); end
    total++; if (a_out.data !== 1'b0) begin bad++; $display("FAIL rst_out got=%0b want=0", a_out.data); end
    total++; if (a_sel_err !== 1'b0) begin bad++; $display("FAIL rst_sel_err got=%0b want=0", a_sel_err); end
    step();
    step();
    rst_n = 1'b1;
    total++; if (a_in.ready !== 1'b0) begin bad++; $display("FAIL rel_in_ready_pre got=%0b want=0", a_in.ready); end
    step();
    total++; if (a_in.ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%0b want=1", a_in.ready); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL rel_b_in_ready got=%0b want=1", b_in_ready); end
  endtask

  task automatic test_select();
    logic [3:0] sels [4] = '{4'd5, 4'd0, 4'd6, 4'd2};
    logic       exp  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    a_in.data = 16'hA5C3;
    for (int i = 0; i < 4; i++) begin
      load_a(sels[i]);
      a_in.valid = 1'b1;
      step();
      a_in.valid = 1'b0;
      total++; if (a_out.valid !== 1'b1) begin bad++; $display("FAIL sel%0d_valid got=%0b want=1", sels[i], a_out.valid); end
      total++; if (a_out.data !== exp[i]) begin bad++; $display("FAIL sel%0d_out got=%0b want=%0b", sels[i], a_out.data, exp[i]); end
      step();
      total++; if (a_out.valid !== 1'b0) begin bad++; $display("FAIL sel%0d_drain got=%0b want=0", sels[i], a_out.valid); end
    end
  endtask

  task automatic test_scan();
    logic exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    a_scan    = 1'b1;
    a_in.data = 16'h4002;
    load_a(4'd14);
    a_in.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (a_out.valid !== 1'b1) begin bad++; $display("FAIL scan%0d_valid got=%0b want=1", i, a_out.valid); end
      total++; if (a_out.data !== exp[i]) begin bad++; $display("FAIL scan%0d_out got=%0b want=%0b", i, a_out.data, exp[i]); end
    end
    a_in.valid = 1'b0;
    a_scan     = 1'b0;
    a_in.data  = 16'h0004;
    step();
    total++; if (a_out.valid !== 1'b0) begin bad++; $display("FAIL scan_drain got=%0b want=0", a_out.valid); end
    a_in.valid = 1'b1;
    step();
    a_in.valid = 1'b0;
    total++; if (a_out.data !== 1'b1) begin bad++; $display("FAIL scan_end_sel2 got=%0b want=1", a_out.data); end
    step();
  endtask

  task automatic test_back_to_back();
    load_a(4'd0);
    a_scan      = 1'b1;
    a_out.ready = 1'b0;
    a_in.data   = 16'h0005;
    a_in.valid  = 1'b1;
    step();
    total++; if (a_in.ready !== 1'b1) begin bad++; $display("FAIL bp1_in_ready got=%0b want=1", a_in.ready); end
    total++; if (a_out.data !== 1'b1) begin bad++; $display("FAIL bp1_out got=%0b want=1", a_out.data); end
    step();
    total++; if (a_in.ready !== 1'b0) begin bad++; $display("FAIL bp2_in_ready got=%0b want=0", a_in.ready); end
    step();
    total++; if (a_in.ready !== 1'b0) begin bad++; $display("FAIL bp3_in_ready got=%0b want=0", a_in.ready); end
    total++; if (a_out.valid !== 1'b1) begin bad++; $display("FAIL bp3_valid got=%0b want=1", a_out.valid); end
    total++; if (a_out.data !== 1'b1) begin bad++; $display("FAIL bp3_stable got=%0b want=1", a_out.data); end
    a_in.valid  = 1'b0;
    a_out.ready = 1'b1;
    step();
    total++; if (a_out.data !== 1'b0) begin bad++; $display("FAIL bp_drain2_out got=%0b want=0", a_out.data); end
    total++; if (a_out.valid !== 1'b1) begin bad++; $display("FAIL bp_drain2_valid got=%0b want=1", a_out.valid); end
    total++; if (a_in.ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_back got=%0b want=1", a_in.ready); end
    step();
    total++; if (a_out.valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b want=0", a_out.valid); end
    // Only two accepts happened, so the scan select must now be 2.
    a_scan     = 1'b0;
    a_in.data  = 16'h0004;
    a_in.valid = 1'b1;
    step();
    a_in.valid = 1'b0;
    total++; if (a_out.data !== 1'b1) begin bad++; $display("FAIL bp_sel2 got=%0b want=1", a_out.data); end
    step();
  endtask

  task automatic test_enable();
    a_en       = 1'b0;
    a_in.data  = 16'hFFFF;
    a_in.valid = 1'b1;
    step();
    a_in.valid = 1'b0;
    total++; if (a_out.valid !== 1'b1) begin bad++; $display("FAIL en0_valid got=%0b want=1", a_out.valid); end
    total++; if (a_out.data !== 1'b0) begin bad++; $display("FAIL en0_out got=%0b want=0", a_out.data); end
    step();
    a_en = 1'b1;
  endtask

  task automatic test_sel_err();
    b_data = 12'hFFF;
    total++; if (b_sel_err !== 1'b0) begin bad++; $display("FAIL err_init got=%0b want=0", b_sel_err); end
    b_sel = 4'd13; b_sel_ld = 1'b1;
    step();
    b_sel_ld = 1'b0;
    total++; if (b_sel_err !== 1'b1) begin bad++; $display("FAIL err_set got=%0b want=1", b_sel_err); end
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    total++; if (b_out_valid !== 1'b1) begin bad++; $display("FAIL err_valid got=%0b want=1", b_out_valid); end
    total++; if (b_out !== 1'b0) begin bad++; $display("FAIL err_out got=%0b want=0", b_out); end
    step();
    b_sel = 4'd3; b_sel_ld = 1'b1;
    step();
    b_sel_ld = 1'b0;
    total++; if (b_sel_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b want=1", b_sel_err); end
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    total++; if (b_out !== 1'b1) begin bad++; $display("FAIL err_sel3_out got=%0b want=1", b_out); end
    step();
    load_a(4'd15);
    total++; if (a_sel_err !== 1'b0) begin bad++; $display("FAIL a_err_pow2 got=%0b want=0", a_sel_err); end
  endtask

  task automatic test_reset_mid();
    a_out.ready = 1'b0;
    a_in.data   = 16'hFFFF;
    a_in.valid  = 1'b1;
    step();
    step();
    a_in.valid = 1'b0;
    total++; if (a_in.ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%0b want=0", a_in.ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_out.valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b want=0", a_out.valid); end
    total++; if (a_out.data !== 1'b0) begin bad++; $display("FAIL mid_out got=%0b want=0", a_out.data); end
    total++; if (a_in.ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%0b want=0", a_in.ready); end
    total++; if (b_sel_err !== 1'b0) begin bad++; $display("FAIL mid_b_err got=%0b want=0", b_sel_err); end
    rst_n       = 1'b1;
    a_out.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (a_out.valid !== 1'b0) begin bad++; $display("FAIL post_rst%0d_valid got=%0b want=0", i, a_out.valid); end
    end
    total++; if (a_in.ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%0b want=1", a_in.ready); end
    a_in.valid = 1'b1;
    step();
    a_in.valid = 1'b0;
    total++; if (a_out.valid !== 1'b1) begin bad++; $display("FAIL post_rst_acc_valid got=%0b want=1", a_out.valid); end
    total++; if (a_out.data !== 1'b1) begin bad++; $display("FAIL post_rst_acc_out got=%0b want=1", a_out.data); end
    step();
  endtask

  initial begin
    rst_n       = 1'b1;
    a_in.data   = '0;
    a_in.valid  = 1'b0;
    a_out.ready = 1'b1;
    a_sel       = '0;
    a_sel_ld    = 1'b0;
    a_scan      = 1'b0;
    a_en        = 1'b1;
    b_data      = '0;
    b_sel       = '0;
    b_sel_ld    = 1'b0;
    b_in_valid  = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_select();
    test_scan();
    test_back_to_back();
    test_enable();
    test_sel_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
